// File: rtl/shift_pkg.sv
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared constants, encodings and types for the multi-cycle
//                16-bit shift sequencer (shift_seq_ctrl / shift_stage).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

  // Datapath geometry; only the 16-bit configuration is supported.
  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  // Operation encodings as presented on the op port.
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Per-operation context captured on the accept edge.
  typedef struct packed {
    logic [1:0]       op;
    logic [AMT_W-1:0] amt;
    logic             sign;   // original operand bit 15, used as SRA fill
  } op_ctx_t;

  // Shift distance applied by barrel stage idx: 1, 2, 4 or 8.
  function automatic logic [4:0] stage_dist(input logic [1:0] idx);
    return 5'd1 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_stage.sv
// ============================================================================
//  Module      : shift_stage
//  Description : One combinational barrel stage. Shifts data by 2^idx when
//                enabled, otherwise passes data through. With SHIFT_FLAGS_EN
//                defined it also reports the last bit shifted out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_stage
  import shift_pkg::*;
(
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       idx_i,
  input  logic             en_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
`ifdef SHIFT_FLAGS_EN
  ,
  output logic             bit_o
`endif
);

  logic [4:0] w_dist;

  assign w_dist = stage_dist(idx_i);

  // Apply this stage's shift/rotate with the fill rule of the operation.
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        OP_SLL:  data_o = data_i << w_dist;
        OP_SRL:  data_o = data_i >> w_dist;
        OP_SRA:  data_o = (data_i >> w_dist) |
                          (sign_i ? ~(16'hFFFF >> w_dist) : 16'h0000);
        default: data_o = (data_i >> w_dist) | (data_i << (5'd16 - w_dist));
      endcase
    end
  end

`ifdef SHIFT_FLAGS_EN
  // Last bit leaving the word: the lowest bit pushed past the MSB for SLL,
  // otherwise the highest bit pushed past the LSB (for ROR that bit lands
  // in the result MSB, which is exactly what the carry flag reports).
  always_comb begin
    bit_o = 1'b0;
    if (en_i) begin
      case (op_i)
        OP_SLL:  bit_o = data_i[4'(5'd16 - w_dist)];
        default: bit_o = data_i[4'(w_dist - 5'd1)];
      endcase
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
// ============================================================================
//  Module      : shift_seq_ctrl
//  Description : Multi-cycle sequencer for the 16-bit shift unit. Accepts one
//                op via valid/ready, runs barrel stages 1/2/4/8 one per cycle
//                through a single shared shift_stage, and holds the result
//                until the consumer takes it. Optional SHIFT_FLAGS_EN macro
//                adds carry/zero outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq_ctrl
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef SHIFT_FLAGS_EN
  ,
  output logic             carry,
  output logic             zero
`endif
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  op_ctx_t          ctx_q, ctx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] w_stage_data;
  logic             w_stage_en;
`ifdef SHIFT_FLAGS_EN
  logic             w_stage_bit;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
`endif

  // Stage k is enabled by amount bit k; cnt selects which stage runs now.
  assign w_stage_en = ctx_q.amt[cnt_q];

  shift_stage u_stage (
    .op_i   (ctx_q.op),
    .data_i (data_q),
    .idx_i  (cnt_q),
    .en_i   (w_stage_en),
    .sign_i (ctx_q.sign),
    .data_o (w_stage_data)
`ifdef SHIFT_FLAGS_EN
    ,
    .bit_o  (w_stage_bit)
`endif
  );

  // Next-state logic: accept in IDLE, four stage cycles in SHIFT, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctx_d   = ctx_q;
    data_d  = data_q;
`ifdef SHIFT_FLAGS_EN
    carry_d = carry_q;
    zero_d  = zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ctx_d.op   = op;
          ctx_d.amt  = amt;
          ctx_d.sign = a[WIDTH-1];
          data_d     = a;
          cnt_d      = 2'd0;
`ifdef SHIFT_FLAGS_EN
          carry_d    = 1'b0;
`endif
          if (amt == '0) begin
            // Nothing to shift: result is the operand, skip the stages.
            state_d = ST_DONE;
`ifdef SHIFT_FLAGS_EN
            zero_d  = (a == '0);
`endif
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d = w_stage_data;
        cnt_d  = cnt_q + 2'd1;
`ifdef SHIFT_FLAGS_EN
        if (w_stage_en) begin
          carry_d = w_stage_bit;
        end
`endif
        if (cnt_q == 2'd3) begin
          state_d = ST_DONE;
`ifdef SHIFT_FLAGS_EN
          zero_d  = (w_stage_data == '0);
`endif
        end
      end
      ST_DONE: begin
        // No accept here: the return to IDLE forces a one-cycle bubble.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      ctx_q   <= '0;
      data_q  <= '0;
`ifdef SHIFT_FLAGS_EN
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctx_q   <= ctx_d;
      data_q  <= data_d;
`ifdef SHIFT_FLAGS_EN
      carry_q <= carry_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = data_q;
`ifdef SHIFT_FLAGS_EN
  assign carry     = carry_q;
  assign zero      = zero_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
// ============================================================================
//  Module      : tb_shift_seq_ctrl
//  Description : Self-checking bench for shift_seq_ctrl with a behavioural
//                reference model. Define SHIFT_FLAGS_EN to cover the flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = 16'h0;
  logic [3:0]  amt = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
`ifdef SHIFT_FLAGS_EN
  logic        carry;
  logic        zero;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  shift_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .amt       (amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef SHIFT_FLAGS_EN
    ,
    .carry     (carry),
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  // Reference result from plain arithmetic on the whole amount.
  function automatic logic [15:0] model_res(input logic [1:0] o, input logic [15:0] av,
                                            input int sh);
    logic [31:0] dbl;
    case (o)
      2'b00:   return av << sh;
      2'b01:   return av >> sh;
      2'b10:   return $signed(av) >>> sh;
      default: begin
        dbl = {av, av} >> sh;
        return dbl[15:0];
      end
    endcase
  endfunction

  // Reference carry: last bit shifted out of the word.
  function automatic logic model_carry(input logic [1:0] o, input logic [15:0] av,
                                       input int sh);
    logic [15:0] r;
    if (sh == 0) return 1'b0;
    r = model_res(o, av, sh);
    case (o)
      2'b00:   return av[16 - sh];
      2'b11:   return r[15];
      default: return av[sh - 1];
    endcase
  endfunction

  // One complete transaction: accept, latency, result, back-pressure, release.
  task automatic run_op(input logic [1:0] o, input logic [15:0] av, input logic [3:0] am,
                        input int hold, input string tag);
    logic [15:0] exp_r;
    int          exp_lat;
    int          edges;
    exp_r   = model_res(o, av, int'(am));
    exp_lat = (am == 4'd0) ? 1 : 5;

    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_ready: got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1; op = o; a = av; amt = am;
    @(negedge clk);
    edges = 1;
    // Scramble inputs: they must only matter on the accept edge.
    in_valid = 1'b0; op = 2'($urandom); a = 16'($urandom); amt = 4'($urandom);
    while (out_valid !== 1'b1 && edges < 12) begin
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy_ready: got %b want 0 (edge %0d)", tag, in_ready, edges);
      end
      in_valid = 1'($urandom);
      @(negedge clk);
      edges++;
    end
    n_tests++;
    if (edges != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d edges", tag, edges, exp_lat);
    end
    n_tests++;
    if (result !== exp_r) begin
      n_fail++;
      $display("FAIL %s result: got %h want %h (op %0d a %h amt %0d)", tag, result, exp_r, o, av, am);
    end
`ifdef SHIFT_FLAGS_EN
    n_tests++;
    if (carry !== model_carry(o, av, int'(am))) begin
      n_fail++;
      $display("FAIL %s carry: got %b want %b", tag, carry, model_carry(o, av, int'(am)));
    end
    n_tests++;
    if (zero !== (exp_r == 16'h0)) begin
      n_fail++;
      $display("FAIL %s zero: got %b want %b", tag, zero, (exp_r == 16'h0));
    end
`endif
    // Back-pressure: result and valid hold, no new op accepted.
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0; in_valid = 1'b1; a = 16'($urandom);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_r) begin
        n_fail++;
        $display("FAIL %s hold: got v=%b r=%b res=%h want v=1 r=0 res=%h", tag, out_valid, in_ready,
                 result, exp_r);
      end
    end
    // Consume with in_valid also high: DONE must not accept (bubble).
    out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: got v=%b r=%b want v=0 r=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = 16'hFFFF; amt = 4'd3;
    repeat (3) @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got r=%b v=%b res=%h want r=1 v=0 res=0000", in_ready, out_valid, result);
    end
`ifdef SHIFT_FLAGS_EN
    n_tests++;
    if (carry !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got c=%b z=%b want 0 0", carry, zero);
    end
`endif
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_directed();
    run_op(2'b00, 16'h0001, 4'd15, 0, "sll_15");
    run_op(2'b10, 16'h8000, 4'd4,  0, "sra_4");
    run_op(2'b01, 16'h8000, 4'd4,  0, "srl_4");
    run_op(2'b11, 16'h1234, 4'd4,  0, "ror_4");
    run_op(2'b01, 16'hABCD, 4'd0,  0, "amt_0");
    run_op(2'b10, 16'h7FFF, 4'd15, 0, "sra_pos_15");
  endtask

  task automatic test_back_to_back();
    run_op(2'b01, 16'hF0F0, 4'd3, 3, "bp_first");
    run_op(2'b11, 16'h8001, 4'd9, 0, "bp_next");
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; op = 2'b00; a = 16'h00FF; amt = 4'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b r=%b res=%h want v=0 r=1 res=0000", out_valid, in_ready, result);
    end
    reset = 1'b0;
    run_op(2'b10, 16'h9000, 4'd5, 1, "after_reset");
  endtask

`ifdef SHIFT_FLAGS_EN
  task automatic test_flags();
    run_op(2'b01, 16'h0003, 4'd1, 0, "flag_srl");
    run_op(2'b00, 16'h8000, 4'd1, 0, "flag_sll");
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [3:0] am;
      am = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
      run_op(2'($urandom), 16'($urandom), am, $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
`ifdef SHIFT_FLAGS_EN
    test_flags();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
